// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word-addressed memory between the
// instruction-fetch (I) and load/store (D) requesters. Round-robin on ties,
// one access in flight, configurable access latency, one-cycle response pulse.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_write,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  owner_e      owner_q;
  owner_e      last_grant_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] i_resp_data_q;
  logic [31:0] d_resp_data_q;

  logic        grant_i;
  logic        grant_d;
  logic        accept;
  logic        busy_last;

  // Arbitration: single valid requester wins; on a tie the side not granted last wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req_valid && d_req_valid) begin
      if (last_grant_q == OWN_D) begin
        grant_i = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
    end else begin
      grant_i = i_req_valid;
      grant_d = d_req_valid;
    end
  end

  // Reset is folded into accept/strobes so an abort takes effect in the reset cycle itself.
  assign accept    = (state_q == IDLE) && !reset && (grant_i || grant_d);
  assign busy_last = (state_q == BUSY) && (cnt_q == 4'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and latched request.
  always_comb begin
    i_req_ready  = accept && grant_i;
    d_req_ready  = accept && grant_d;
    mem_read     = (state_q == BUSY) && !write_q;
    mem_write    = busy_last && write_q && !reset;
    i_resp_valid = (state_q == RESP) && (owner_q == OWN_I) && !reset;
    d_resp_valid = (state_q == RESP) && (owner_q == OWN_D) && !reset;
    mem_addr     = addr_q;
    mem_din      = wdata_q;
    i_resp_data  = i_resp_data_q;
    d_resp_data  = d_resp_data_q;
  end

  // Request latch, latency counter and response data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q       <= OWN_I;
      last_grant_q  <= OWN_D;
      cnt_q         <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      i_resp_data_q <= '0;
      d_resp_data_q <= '0;
    end else begin
      if (accept) begin
        owner_q      <= grant_i ? OWN_I : OWN_D;
        last_grant_q <= grant_i ? OWN_I : OWN_D;
        addr_q       <= grant_i ? i_req_addr : d_req_addr;
        write_q      <= grant_d && d_req_write;
        wdata_q      <= grant_i ? '0 : d_req_wdata;
        cnt_q        <= CNT_LOAD;
      end
      // cnt holds at zero on the last BUSY cycle instead of wrapping.
      if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (busy_last) begin
        if (owner_q == OWN_I) begin
          i_resp_data_q <= mem_dout;
        end else begin
          d_resp_data_q <= write_q ? '0 : mem_dout;
        end
      end
    end
  end

endmodule
